// File: rtl/sram_wb_ctrl_pkg.sv
// Shared definitions for the Wishbone-to-async-SRAM controller:
// the controller state encoding, the wait counter width and the
// default SRAM geometry used when no parameters are overridden.
package sram_pkg;

    localparam int WAIT_CTR_WIDTH     = 4;
    localparam int DEFAULT_ADDR_WIDTH = 20;
    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        ACK
    } state_e;

endpackage

// File: rtl/sram_wb_ctrl_if.sv
// Wishbone classic bus bundle between a mentor and the SRAM controller.
// Signal names follow the Wishbone slave view (_I into the slave, _O out).
interface sram_wb_ctrl_if
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

    logic                  CYC_I;
    logic                  STB_I;
    logic                  WE_I;
    logic [ADDR_WIDTH-1:0] ADR_I;
    logic [DATA_WIDTH-1:0] DAT_I;
    logic [DATA_WIDTH-1:0] DAT_O;
    logic                  ACK_O;
    logic                  ERR_O;
    logic                  RTY_O;

    modport master (
        output CYC_I, STB_I, WE_I, ADR_I, DAT_I,
        input  DAT_O, ACK_O, ERR_O, RTY_O
    );

    modport slave (
        input  CYC_I, STB_I, WE_I, ADR_I, DAT_I,
        output DAT_O, ACK_O, ERR_O, RTY_O
    );

endinterface

// File: rtl/sram_wb_ctrl_wait_ctr.sv
// Strobe-length counter for the SRAM controller. It is loaded with
// WAIT_STATES while the controller sits in SETUP and counts down once
// per STROBE cycle; done_o tells the controller the strobe may end.
module sram_wait_ctr
    import sram_pkg::*;
#(
    parameter int WAIT_STATES = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic dec_i,
    output logic done_o
);

    localparam logic [WAIT_CTR_WIDTH-1:0] LOAD_VALUE = WAIT_CTR_WIDTH'(WAIT_STATES);
    localparam logic [WAIT_CTR_WIDTH-1:0] ONE        = WAIT_CTR_WIDTH'(1);

    logic [WAIT_CTR_WIDTH-1:0] count_q;
    logic [WAIT_CTR_WIDTH-1:0] count_d;

    // Next count: reload takes priority, otherwise step down and park at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = LOAD_VALUE;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - ONE;
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/sram_wb_ctrl.sv
// Wishbone classic slave driving an external asynchronous SRAM.
// Each access runs IDLE -> SETUP -> STROBE -> ACK -> IDLE. All pin
// outputs are registered and take the value decided in a state at the
// edge that leaves it, so the pins trail the state register by one
// cycle: address setup, then data/OE, then the WE strobe, then ACK.
// Holding CYC_I/STB_I across ACK chains beats into a block transfer.
// Optional build macro SRAM_ADDR_CHECK_EN: addresses at or above
// MEM_DEPTH are answered with a one-cycle ERR_O and never reach the SRAM.
module sram_wb_ctrl
    import sram_pkg::*;
#(
    parameter int              ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int              DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int              WAIT_STATES = 1,
    parameter longint unsigned MEM_DEPTH   = 64'd1 << ADDR_WIDTH
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    sram_wb_ctrl_if.slave         wb,
    output logic [ADDR_WIDTH-1:0] o_addr,
    inout  wire  [DATA_WIDTH-1:0] io_c_data,
    output logic                  o_n_oe,
    output logic                  o_n_we
);

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  we_q;
    logic                  drive_q;
    logic                  n_oe_q;
    logic                  n_we_q;
    logic                  ack_q;
    logic                  req;
    logic                  resp_hold;
    logic                  ctr_done;

`ifdef SRAM_ADDR_CHECK_EN
    logic                  err_q;
    logic                  bad_q;
    logic                  addr_bad;

    assign addr_bad  = (64'(wb.ADR_I) >= MEM_DEPTH);
    assign resp_hold = ack_q | err_q;
    assign wb.ERR_O  = err_q;
`else
    assign resp_hold = ack_q;
    assign wb.ERR_O  = 1'b0;
`endif

    assign req = wb.CYC_I & wb.STB_I;

    sram_wait_ctr #(
        .WAIT_STATES (WAIT_STATES)
    ) u_wait_ctr (
        .clk_i  (CLK_I),
        .rst_i  (RST_I),
        .load_i (state_q == SETUP),
        .dec_i  (state_q == STROBE),
        .done_o (ctr_done)
    );

    // Access sequencer and registered SRAM/bus pin drivers.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            drive_q <= 1'b0;
            n_oe_q  <= 1'b1;
            n_we_q  <= 1'b1;
            ack_q   <= 1'b0;
`ifdef SRAM_ADDR_CHECK_EN
            err_q   <= 1'b0;
            bad_q   <= 1'b0;
`endif
        end else begin
            ack_q <= 1'b0;
`ifdef SRAM_ADDR_CHECK_EN
            err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    drive_q <= 1'b0;
                    if (req && !resp_hold) begin
                        addr_q  <= wb.ADR_I;
                        wdata_q <= wb.DAT_I;
                        we_q    <= wb.WE_I;
`ifdef SRAM_ADDR_CHECK_EN
                        bad_q   <= addr_bad;
                        state_q <= addr_bad ? ACK : SETUP;
`else
                        state_q <= SETUP;
`endif
                    end
                end

                SETUP: begin
                    if (!wb.CYC_I) begin
                        drive_q <= 1'b0;
                        n_oe_q  <= 1'b1;
                        n_we_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        if (we_q) begin
                            drive_q <= 1'b1;
                        end else begin
                            n_oe_q  <= 1'b0;
                        end
                        state_q <= STROBE;
                    end
                end

                STROBE: begin
                    if (!wb.CYC_I) begin
                        drive_q <= 1'b0;
                        n_oe_q  <= 1'b1;
                        n_we_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        if (we_q) begin
                            n_we_q <= 1'b0;
                        end
                        if (ctr_done) begin
                            state_q <= ACK;
                        end
                    end
                end

                ACK: begin
                    n_we_q  <= 1'b1;
                    n_oe_q  <= 1'b1;
                    state_q <= IDLE;
                    if (req) begin
`ifdef SRAM_ADDR_CHECK_EN
                        if (bad_q) begin
                            err_q <= 1'b1;
                        end else begin
                            ack_q <= 1'b1;
                            if (!we_q) begin
                                rdata_q <= io_c_data;
                            end
                        end
`else
                        ack_q <= 1'b1;
                        if (!we_q) begin
                            rdata_q <= io_c_data;
                        end
`endif
                    end else begin
                        drive_q <= 1'b0;
                    end
                end

                default: begin
                    drive_q <= 1'b0;
                    n_oe_q  <= 1'b1;
                    n_we_q  <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_addr    = addr_q;
    assign o_n_oe    = n_oe_q;
    assign o_n_we    = n_we_q;
    assign io_c_data = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};

    assign wb.DAT_O  = rdata_q;
    assign wb.ACK_O  = ack_q;
    assign wb.RTY_O  = 1'b0;

endmodule

// File: tb/tb_sram_wb_ctrl.sv
// Self-checking bench for sram_wb_ctrl: a Wishbone mentor issues
// directed and random beats, pushes the expected response into a queue,
// and a negedge monitor pops and compares whenever ACK_O/ERR_O shows.
// A simple SRAM array model sits on the pins; the expected memory
// contents live in a separate reference array.
module tb_sram_wb_ctrl;

    localparam int              AW    = 12;
    localparam int              DW    = 8;
    localparam int              WS    = 1;
    localparam longint unsigned DEPTH = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    sram_wb_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) wb ();

    wire  [DW-1:0] io_c_data;
    logic [AW-1:0] o_addr;
    logic          o_n_oe;
    logic          o_n_we;

    sram_wb_ctrl #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .WAIT_STATES (WS),
        .MEM_DEPTH   (DEPTH)
    ) dut (
        .CLK_I     (clk),
        .RST_I     (rst),
        .wb        (wb.slave),
        .o_addr    (o_addr),
        .io_c_data (io_c_data),
        .o_n_oe    (o_n_oe),
        .o_n_we    (o_n_we)
    );

    logic [DW-1:0] sram   [0:(1<<AW)-1];
    logic [DW-1:0] refMem [0:(1<<AW)-1];

    // SRAM chip model: drives data while OE is low, stores while WE is low
    assign io_c_data = (!o_n_oe) ? sram[o_addr] : {DW{1'bz}};

    always @(posedge clk) begin
        if (!o_n_we) sram[o_addr] <= io_c_data;
    end

    int cycleCnt = 0;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    typedef struct {
        bit isErr;
        bit isWrite;
        int adr;
        int dat;
        int expDatO;
        int cycle;
    } exp_t;

    exp_t expQ[$];
    int   total = 0;
    int   bad = 0;
    int   respCount = 0;
    int   lastRespCycle = 0;
    int   prevRespCycle = 0;
    int   weLow = 0;
    int   oeLow = 0;
    int   modelDatO = 0;

    task automatic checkOutput(input string name, input longint actual, input longint required);
        total++;
        if (actual != required) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, required, $time);
        end
    endtask

    function automatic bit hiZ();
        return (io_c_data === {DW{1'bz}}) || (io_c_data === {DW{1'b0}});
    endfunction

    function automatic bit addrErr(input int adr);
`ifdef SRAM_ADDR_CHECK_EN
        return (longint'(adr) >= longint'(DEPTH));
`else
        return 1'b0;
`endif
    endfunction

    // Monitor: pin activity, write-pin values and response scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                weLow = 0;
                oeLow = 0;
            end else begin
                if (!o_n_we) weLow++;
                if (!o_n_oe) oeLow++;
                checkOutput("strobeOverlap", longint'(!o_n_we && !o_n_oe), 0);
                if (!o_n_we && expQ.size() > 0) begin
                    checkOutput("wrAddr", longint'(o_addr), longint'(expQ[0].adr));
                    checkOutput("wrData", longint'(io_c_data), longint'(expQ[0].dat));
                end
                if (wb.ACK_O || wb.ERR_O) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpectedResp", longint'({wb.ACK_O, wb.ERR_O}), 0);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("respKind", longint'({wb.ACK_O, wb.ERR_O}), e.isErr ? 1 : 2);
                        checkOutput("respCycle", cycleCnt, e.cycle);
                        checkOutput("datO", longint'(wb.DAT_O), e.expDatO);
                        checkOutput("weLowCycles", weLow, (e.isWrite && !e.isErr) ? WS + 1 : 0);
                        checkOutput("oeLowCycles", oeLow, (!e.isWrite && !e.isErr) ? WS + 2 : 0);
                    end
                    prevRespCycle = lastRespCycle;
                    lastRespCycle = cycleCnt;
                    respCount++;
                    weLow = 0;
                    oeLow = 0;
                end
            end
        end
    end

    // One mentor beat; must be entered just after a rising edge
    task automatic applyStimulus(input bit we, input int adr, input int dat, input bit keep);
        exp_t e;
        int   start;
        bit   got;
        e.isErr   = addrErr(adr);
        e.isWrite = we;
        e.adr     = adr;
        e.dat     = dat;
        if (!we && !e.isErr) modelDatO = int'(refMem[adr]);
        if (we && !e.isErr) refMem[adr] = dat[DW-1:0];
        e.expDatO = modelDatO;
        e.cycle   = cycleCnt + (e.isErr ? 2 : WS + 4);
        expQ.push_back(e);
        wb.CYC_I = 1'b1;
        wb.STB_I = 1'b1;
        wb.WE_I  = we;
        wb.ADR_I = adr[AW-1:0];
        wb.DAT_I = dat[DW-1:0];
        start = respCount;
        got   = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(posedge clk);
            if (respCount != start) got = 1'b1;
        end
        checkOutput("respTimeout", longint'(got), 1);
        if (!got) expQ.delete();
        #1;
        if (!keep) begin
            wb.CYC_I = 1'b0;
            wb.STB_I = 1'b0;
            wb.WE_I  = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int blockDat[3];
        bit we;
        int adr;
        bit keep;
        int startResp;

        for (int i = 0; i < (1 << AW); i++) begin
            sram[i]   = '0;
            refMem[i] = '0;
        end
        wb.CYC_I = 1'b0;
        wb.STB_I = 1'b0;
        wb.WE_I  = 1'b0;
        wb.ADR_I = '0;
        wb.DAT_I = '0;
        rst      = 1'b1;

        // Reset hold with strobes pulsing
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            wb.CYC_I = 1'b1;
            wb.STB_I = i[0];
            wb.WE_I  = 1'b1;
            wb.DAT_I = 8'h5A;
            @(negedge clk);
            checkOutput("rstAck", longint'(wb.ACK_O), 0);
            checkOutput("rstErr", longint'(wb.ERR_O), 0);
            checkOutput("rstNOe", longint'(o_n_oe), 1);
            checkOutput("rstNWe", longint'(o_n_we), 1);
            checkOutput("rstHiZ", longint'(hiZ()), 1);
            checkOutput("rstAddr", longint'(o_addr), 0);
            checkOutput("rstDatO", longint'(wb.DAT_O), 0);
        end
        @(posedge clk);
        #1;
        rst      = 1'b0;
        wb.CYC_I = 1'b0;
        wb.STB_I = 1'b0;
        wb.WE_I  = 1'b0;

        // Single write then single read back
        applyStimulus(1'b1, 1777, 'hC9, 1'b0);
        applyStimulus(1'b0, 1777, 0, 1'b0);

        // Block transfer: three writes then three reads under a held CYC
        blockDat[0] = 'hA5;
        blockDat[1] = 'h5A;
        blockDat[2] = 'hFF;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, i, blockDat[i], 1'b1);
            if (i > 0) checkOutput("blockWrSpacing", lastRespCycle - prevRespCycle, WS + 5);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, i, 0, i != 2);
            checkOutput("blockRdSpacing", lastRespCycle - prevRespCycle, WS + 5);
        end

        // Abort: drop CYC during the first STROBE cycle of a write
        startResp = respCount;
        wb.CYC_I = 1'b1;
        wb.STB_I = 1'b1;
        wb.WE_I  = 1'b1;
        wb.ADR_I = AW'(5);
        wb.DAT_I = 8'h3C;
        @(posedge clk);
        @(posedge clk);
        #1;
        wb.CYC_I = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abortNWe", longint'(o_n_we), 1);
        checkOutput("abortNOe", longint'(o_n_oe), 1);
        checkOutput("abortHiZ", longint'(hiZ()), 1);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("abortNoAck", respCount - startResp, 0);
        wb.STB_I = 1'b0;
        wb.WE_I  = 1'b0;
        applyStimulus(1'b0, 5, 0, 1'b0);

        // Address beyond populated depth
        applyStimulus(1'b1, 2000, 'h77, 1'b0);
        applyStimulus(1'b0, 2000, 0, 1'b0);

        // Reset in the middle of a write while data is being driven
        wb.CYC_I = 1'b1;
        wb.STB_I = 1'b1;
        wb.WE_I  = 1'b1;
        wb.ADR_I = AW'(9);
        wb.DAT_I = 8'hC3;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midRstNWe", longint'(o_n_we), 1);
        checkOutput("midRstNOe", longint'(o_n_oe), 1);
        checkOutput("midRstHiZ", longint'(hiZ()), 1);
        checkOutput("midRstAck", longint'(wb.ACK_O), 0);
        checkOutput("midRstDatO", longint'(wb.DAT_O), 0);
        checkOutput("midRstAddr", longint'(o_addr), 0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        wb.CYC_I  = 1'b0;
        wb.STB_I  = 1'b0;
        wb.WE_I   = 1'b0;
        modelDatO = 0;
        applyStimulus(1'b0, 9, 0, 1'b0);

        // Random mix of reads, writes, out-of-range addresses and gaps
        for (int n = 0; n < 60; n++) begin
            we   = 1'(($urandom_range(0, 1)));
            adr  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1024, 4095))
                                               : int'($urandom_range(0, 31));
            keep = 1'($urandom_range(0, 1));
            applyStimulus(we, adr, int'($urandom_range(0, 255)), keep);
            if (!keep && ($urandom_range(0, 1) == 1)) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        wb.CYC_I = 1'b0;
        wb.STB_I = 1'b0;

        repeat (5) @(posedge clk);
        checkOutput("queueDrained", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
